truth_table_scanner: RTL and testbench



---
 rtl/truth_table_scanner.sv | 155 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Sequential truth-table reader: walks stim through every input combination,
// samples resp after a settle delay and builds the output column in table_out.
// Optional comparison against EXPECTED is enabled by defining TT_COMPARE_EN.
module truth_table_scanner #(
  parameter int                    N_IN     = 3,
  parameter int                    SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'hD7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     resp,
  output logic [N_IN-1:0]          stim,
  output logic                     busy,
  output logic                     done,
  output logic [(2**N_IN)-1:0]     table_out,
  output logic                     match,
  output logic [N_IN:0]            mismatch_cnt,
  output logic [N_IN-1:0]          first_fail
);

  localparam logic [N_IN-1:0] LAST_ROW   = '1;
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // After a row is launched, SETTLE=0 skips the wait state entirely.
  localparam state_t ROW_START = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t                 state_q, state_d;
  logic [N_IN-1:0]        stim_q, stim_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [(2**N_IN)-1:0]   table_q, table_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

`ifdef TT_COMPARE_EN
  logic                   match_q, match_d;
  logic [N_IN:0]          mcnt_q, mcnt_d;
  logic [N_IN-1:0]        ff_q, ff_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef TT_COMPARE_EN
    match_d = match_q;
    mcnt_d  = mcnt_q;
    ff_d    = ff_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          table_d = '0;
          stim_d  = '0;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_CNT;
          state_d = ROW_START;
`ifdef TT_COMPARE_EN
          match_d = 1'b0;
          mcnt_d  = '0;
          ff_d    = '0;
`endif
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        table_d[stim_q] = resp;
`ifdef TT_COMPARE_EN
        if (resp != EXPECTED[stim_q]) begin
          mcnt_d = mcnt_q + 1'b1;
          if (mcnt_q == '0) ff_d = stim_q;
        end
`endif
        if (stim_q == LAST_ROW) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef TT_COMPARE_EN
          match_d = (table_d == EXPECTED);
`endif
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = SETTLE_CNT;
          state_d = ROW_START;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TT_COMPARE_EN
      match_q <= 1'b0;
      mcnt_q  <= '0;
      ff_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TT_COMPARE_EN
      match_q <= match_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
`endif
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;

`ifdef TT_COMPARE_EN
  assign match        = match_q;
  assign mismatch_cnt = mcnt_q;
  assign first_fail   = ff_q;
`else
  assign match        = 1'b0;
  assign mismatch_cnt = '0;
  assign first_fail   = '0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: expected scan results are queued
// when a start is driven and compared when the DUT pulses done.
module tb_truth_table_scanner;

  typedef struct {
    logic [7:0] tbl;
    logic       match;
    logic [3:0] cnt;
    logic [2:0] ff;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic       resp0, resp1;
  logic       mode_ones;
  logic [2:0] stim0, stim1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] table0, table1;
  logic       match0, match1;
  logic [3:0] mcnt0, mcnt1;
  logic [2:0] ff0, ff1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  truth_table_scanner #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hD7)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .resp(resp0),
    .stim(stim0), .busy(busy0), .done(done0), .table_out(table0),
    .match(match0), .mismatch_cnt(mcnt0), .first_fail(ff0)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hD7)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .resp(resp1),
    .stim(stim1), .busy(busy1), .done(done1), .table_out(table1),
    .match(match1), .mismatch_cnt(mcnt1), .first_fail(ff1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic f_pos(input logic [2:0] s);
    logic x, y, z;
    x = s[2]; y = s[1]; z = s[0];
    return (~x | y | ~z) & (x | ~y | ~z);
  endfunction

  always_comb resp0 = mode_ones ? 1'b1 : f_pos(stim0);
  always_comb resp1 = stim1[0];

  function automatic logic [7:0] f_table();
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t[i] = f_pos(3'(i));
    return t;
  endfunction

  function automatic exp_t model(input logic [7:0] tbl, input logic [7:0] expm,
                                 input int done_cyc);
    exp_t e;
    logic [7:0] diff;
    e.tbl      = tbl;
    e.done_cyc = done_cyc;
    e.match    = 1'b0;
    e.cnt      = '0;
    e.ff       = '0;
`ifdef TT_COMPARE_EN
    diff    = tbl ^ expm;
    e.match = (diff == 8'h00);
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) begin
        e.cnt = e.cnt + 4'd1;
        e.ff  = 3'(i);
      end
    end
`else
    diff = expm;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0)
      check("scan_timeout", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) check("unexpected_done0", 1, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("done0_cycle", 32'(cyc), 32'(e.done_cyc));
        check("table0", 32'(table0), 32'(e.tbl));
        check("match0", 32'(match0), 32'(e.match));
        check("mcnt0", 32'(mcnt0), 32'(e.cnt));
        check("ff0", 32'(ff0), 32'(e.ff));
        check("busy0_at_done", 32'(busy0), 0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) check("unexpected_done1", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("done1_cycle", 32'(cyc), 32'(e.done_cyc));
        check("table1", 32'(table1), 32'(e.tbl));
        check("match1", 32'(match1), 32'(e.match));
        check("mcnt1", 32'(mcnt1), 32'(e.cnt));
        check("ff1", 32'(ff1), 32'(e.ff));
      end
    end
  end

  initial begin
    int acc;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode_ones = 1'b0;
    repeat (3) tick();
    check("rst_stim", 32'(stim0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_table", 32'(table0), 0);
    check("rst_match", 32'(match0), 0);
    check("rst_mcnt", 32'(mcnt0), 0);
    check("rst_ff", 32'(ff0), 0);
    reset = 1'b0;
    tick();

    // Scan 1: default function, stim steps every two cycles, done 16 edges in.
    acc = cyc + 1;
    q0.push_back(model(f_table(), 8'hD7, acc + 16));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("scan_stim", 32'(stim0), 32'(k / 2));
      check("scan_busy", 32'(busy0), 1);
      tick();
    end
    tick();
    check("hold_stim", 32'(stim0), 7);
    check("hold_table", 32'(table0), 32'(f_table()));
    check("hold_done_low", 32'(done0), 0);
    wait_empty(100);

    // Scan 2: resp stuck high.
    mode_ones = 1'b1;
    tick();
    acc = cyc + 1;
    q0.push_back(model(8'hFF, 8'hD7, acc + 16));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_empty(100);
    mode_ones = 1'b0;

    // Scan 3: zero settle time, one row per cycle.
    tick();
    acc = cyc + 1;
    q1.push_back(model(8'hAA, 8'hD7, acc + 8));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_empty(100);

    // Scan 4: reset at edge 7 aborts; restart at edge 9 completes at edge 25.
    tick();
    acc = cyc + 1;
    q0.push_back(model(f_table(), 8'hD7, acc + 16));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    q0.delete();
    check("abort_stim", 32'(stim0), 0);
    check("abort_busy", 32'(busy0), 0);
    check("abort_table", 32'(table0), 0);
    check("abort_done", 32'(done0), 0);
    reset = 1'b0;
    tick();
    q0.push_back(model(f_table(), 8'hD7, acc + 25));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_empty(100);

    // Reset and start on the same edge: stays idle.
    tick();
    reset = 1'b1;
    start0 = 1'b1;
    tick();
    reset = 1'b0;
    start0 = 1'b0;
    check("rst_start_busy", 32'(busy0), 0);
    tick();
    check("rst_start_idle", 32'(busy0), 0);

    // Start held high for 40 edges: scans accepted at +0, +18 and +36.
    acc = cyc + 1;
    q0.push_back(model(f_table(), 8'hD7, acc + 16));
    q0.push_back(model(f_table(), 8'hD7, acc + 34));
    q0.push_back(model(f_table(), 8'hD7, acc + 52));
    start0 = 1'b1;
    repeat (40) tick();
    start0 = 1'b0;
    wait_empty(100);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
